// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory with a combinational CPU load/store port
// and a registered VGA read port. A sequencer zeroes the array after each reset.
module data_memory_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        wsize,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [31:0]       vga_rdata,
  output logic              vga_valid
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned PtrW  = ADDR_W - 2;

  typedef enum logic {StClear, StReady} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [7:0]        mem_q [Depth];
  logic [31:0]       vga_rdata_q;
  logic              vga_valid_q;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [31:0]       cpu_word, vga_word;

  // Offsets wrap naturally at the top of memory through ADDR_W-bit arithmetic.
  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    return {mem_q[a], mem_q[a + ADDR_W'(1)], mem_q[a + ADDR_W'(2)], mem_q[a + ADDR_W'(3)]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      ptr_q   <= '0;
    end else if (state_q == StClear) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (&ptr_q) state_q <= StReady;
    end
  end

  assign ready = (state_q == StReady);

  assign a1 = address + ADDR_W'(1);
  assign a2 = address + ADDR_W'(2);
  assign a3 = address + ADDR_W'(3);

  // Array has no reset; the clear sequencer owns it until ready.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[{ptr_q, 2'b00}] <= 8'h00;
      mem_q[{ptr_q, 2'b01}] <= 8'h00;
      mem_q[{ptr_q, 2'b10}] <= 8'h00;
      mem_q[{ptr_q, 2'b11}] <= 8'h00;
    end else if (we) begin
      case (wsize)
        2'b00: mem_q[address] <= wdata[7:0];
        2'b01: begin
          mem_q[address] <= wdata[15:8];
          mem_q[a1]      <= wdata[7:0];
        end
        2'b10: begin
          mem_q[address] <= wdata[31:24];
          mem_q[a1]      <= wdata[23:16];
          mem_q[a2]      <= wdata[15:8];
          mem_q[a3]      <= wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign cpu_word = word_at(address);
  assign vga_word = word_at(vga_addr);
  assign rdata    = ready ? cpu_word : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_valid_q <= 1'b0;
      vga_rdata_q <= 32'h0;
    end else begin
      vga_valid_q <= vga_req;
      if (vga_req) vga_rdata_q <= ready ? vga_word : 32'h0;
    end
  end

  assign vga_rdata = vga_rdata_q;
  assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: clear timing, store sizes, wrap, VGA port, reset restart.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        we;
  logic [1:0]  wsize;
  logic [7:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        vga_req;
  logic [7:0]  vga_addr;
  logic [31:0] vga_rdata;
  logic        vga_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n;

  data_memory_ctrl #(.ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .we        (we),
    .wsize     (wsize),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_rdata (vga_rdata),
    .vga_valid (vga_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; wsize = sz; address = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wsize = 2'b00; address = 8'h00; wdata = 32'h0;
    vga_req = 1'b0; vga_addr = 8'h00;
    tick();
    tick();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_vga_valid", {31'b0, vga_valid}, 32'd0);
    chk("rst_vga_rdata", vga_rdata, 32'h0);

    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, 32'd64);
    rd(8'hFC, "read_fc_cleared", 32'h0);

    // Read-during-write: old contents before the edge.
    we = 1'b1; wsize = 2'b10; address = 8'h10; wdata = 32'h11223344;
    #1;
    chk("rdw_old", rdata, 32'h0);
    tick();
    we = 1'b0;
    rd(8'h10, "word_store", 32'h11223344);
    store(2'b00, 8'h11, 32'h000000AA);
    store(2'b01, 8'h12, 32'h0000BEEF);
    rd(8'h10, "mixed_sizes", 32'h11AABEEF);

    store(2'b10, 8'hFE, 32'hDEADBEEF);
    rd(8'hFE, "wrap_fe", 32'hDEADBEEF);
    rd(8'hFF, "wrap_ff", 32'hADBEEF00);
    rd(8'h00, "wrap_00", 32'hBEEF0000);

    // Three back-to-back VGA requests with an overlapping store on the second.
    vga_req = 1'b1; vga_addr = 8'h10;
    tick();
    chk("vga1_valid", {31'b0, vga_valid}, 32'd1);
    chk("vga1_data", vga_rdata, 32'h11AABEEF);
    we = 1'b1; wsize = 2'b10; address = 8'h10; wdata = 32'hCAFEF00D;
    tick();
    we = 1'b0;
    chk("vga2_valid", {31'b0, vga_valid}, 32'd1);
    chk("vga2_data", vga_rdata, 32'h11AABEEF);
    tick();
    chk("vga3_valid", {31'b0, vga_valid}, 32'd1);
    chk("vga3_data", vga_rdata, 32'hCAFEF00D);
    vga_req = 1'b0;
    tick();
    chk("vga4_valid", {31'b0, vga_valid}, 32'd0);

    store(2'b10, 8'h20, 32'h01020304);
    store(2'b11, 8'h20, 32'hFFFFFFFF);
    rd(8'h20, "reserved_size", 32'h01020304);

    // Reset from READY, then restart mid-clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vga_req = 1'b1; vga_addr = 8'h20;
    we = 1'b1; wsize = 2'b10; address = 8'h40; wdata = 32'h12345678;
    tick();
    chk("clear_vga_valid", {31'b0, vga_valid}, 32'd1);
    chk("clear_vga_zero", vga_rdata, 32'h0);
    vga_req = 1'b0; we = 1'b0;
    rd(8'h20, "clear_rdata_forced", 32'h0);
    repeat (29) tick();
    chk("mid_clear_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("restart_cycles", n, 32'd64);
    rd(8'h40, "dropped_store", 32'h0);
    rd(8'h10, "reclear_10", 32'h0);
    rd(8'h20, "reclear_20", 32'h0);
    rd(8'hFE, "reclear_fe", 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Byte-addressed, big-endian data memory for the processor's data path with a CPU load/store port and a registered display read port for the VGA controller. Generalised in depth, it adds byte/halfword/word stores and a reset-triggered clear sequencer. The CPU port reads combinationally; the VGA port reads through a one-cycle registered request/valid handshake. The block sits between the execute/memory stage and the VGA pixel fetch logic.

## Interface
- ADDR_W, 8, byte-address width; memory holds 2^ADDR_W bytes (minimum 4).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched, ready immediately.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  high when the clear sequence is finished and stores are accepted.
- we  in  1  CPU store enable.
- wsize  in  2  store size: 00 byte, 01 halfword, 10 word, 11 reserved (no write).
- address  in  ADDR_W  CPU byte address.
- wdata  in  32  CPU store data, right-aligned.
- rdata  out  32  CPU load word {M[a],M[a+1],M[a+2],M[a+3]}, combinational.
- vga_req  in  1  VGA read request.
- vga_addr  in  ADDR_W  VGA byte address.
- vga_rdata  out  32  registered VGA word, same byte order as rdata.
- vga_valid  out  1  one-cycle pulse, vga_rdata valid.

## Operation
- Byte order: lowest address holds the most significant byte. All offsets a+k are computed modulo 2^ADDR_W (wrap at top of memory, no error).
- Stores (we=1, ready=1, rising edge): byte writes wdata[7:0] to M[a]; halfword writes wdata[15:8] to M[a], wdata[7:0] to M[a+1]; word writes wdata[31:24..7:0] to M[a..a+3]. Unaligned addresses are legal. wsize=11 writes nothing.
- Stores with ready=0 are dropped silently.
- rdata reflects array contents combinationally; while ready=0 and CLEAR_ON_RESET=1, rdata is forced to 0.
- Sequencer states: CLEAR, READY.
  - rst asserted: state=CLEAR (or READY if CLEAR_ON_RESET=0), clear pointer=0.
  - CLEAR: each cycle writes zero to 4 bytes at pointer, pointer += 4; after the write at 2^ADDR_W-4, go to READY.
  - READY: terminal until next reset.
- VGA port: vga_req=1 on edge N captures the word at vga_addr; vga_rdata/vga_valid update at edge N, visible cycle N+1. vga_valid=0 in any cycle following a cycle without vga_req. Back-to-back requests give one result per cycle.
- VGA requests during CLEAR are accepted and return 0.

## Timing
- Reset values: ready=0 (1 if CLEAR_ON_RESET=0), vga_valid=0, vga_rdata=0, clear pointer=0.
- Clear duration: 2^ADDR_W/4 cycles after rst deasserts (64 for ADDR_W=8); ready rises on the edge that performs the last clear write.
- Reset mid-clear restarts the pointer at 0. Reset during READY with CLEAR_ON_RESET=1 re-clears all contents.
- Read-during-write, same edge: CPU rdata shows old data until the edge, new data after it. A VGA capture on the same edge as an overlapping store returns old bytes.
- Store latency: visible on rdata one edge after we.
- VGA latency: exactly 1 cycle, no stalls.

## Test plan
- Reset with ADDR_W=8: ready low for exactly 64 cycles after rst falls, then high; a word read at 0xFC returns 0x00000000.
- Word store 0x11223344 to 0x10, then byte 0xAA to 0x11 and halfword 0xBEEF to 0x12 -> rdata @0x10 = 0x11AABEEF.
- Word store 0xDEADBEEF to 0xFE -> M[0xFE]=DE, M[0xFF]=AD, M[0x00]=BE, M[0x01]=EF; rdata @0xFE = 0xDEADBEEF.
- VGA req @0x10 on three consecutive cycles with a word store 0xCAFEF00D to 0x10 on the second -> vga_rdata = 0x11AABEEF, 0x11AABEEF, 0xCAFEF00D; valid high for 3 cycles, then low.
- Assert rst at clear cycle 30 for 2 cycles -> ready stays low a further 64 cycles after release; a store issued while ready=0 is not present afterwards.
- wsize=11 with we=1 to 0x20 after storing 0x01020304 -> rdata @0x20 remains 0x01020304.
